// File: rtl/level_loader.sv
// level_loader: streams one level's object table from the level ROM into a
// shadow bank, then swaps it into the active info_* tables at a frame boundary.
module level_loader #(
    parameter int unsigned N_GROUND = 16,
    parameter int unsigned N_FENCE  = 16,
    parameter int unsigned N_SPINCE = 6,
    parameter int unsigned LVL_W    = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load_req,
    input  logic [LVL_W-1:0]  level_id,
    input  logic              frame_end,
    output logic              busy,
    output logic              done,
    output logic              rom_rd,
    output logic [LVL_W+5:0]  rom_addr,
    input  logic [28:0]       rom_data,
    output logic [28:0]       info_ground [N_GROUND],
    output logic [28:0]       info_fence  [N_FENCE],
    output logic [20:0]       info_spince [N_SPINCE],
    output logic [9:0]        info_exit   [2]
);

    localparam int unsigned IDX_W       = 6;
    localparam int unsigned FENCE_BASE  = N_GROUND;
    localparam int unsigned SPINCE_BASE = N_GROUND + N_FENCE;
    localparam int unsigned EXIT_BASE   = SPINCE_BASE + N_SPINCE;
    localparam int unsigned LAST_IDX    = EXIT_BASE + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WAIT
    } state_t;

    state_t              state;
    logic                cap_vld;
    logic [IDX_W-1:0]    cap_idx;
    logic                commit_c;

    logic [28:0] sh_ground [N_GROUND];
    logic [28:0] sh_fence  [N_FENCE];
    logic [20:0] sh_spince [N_SPINCE];
    logic [9:0]  sh_exit   [2];

    // Frame boundary seen while a complete shadow bank is waiting
    assign commit_c = (state == S_WAIT) && frame_end;

    // Load sequencer: accept request, walk word indices, drain, wait for frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rom_rd   <= 1'b0;
            rom_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_req) begin
                        state    <= S_FETCH;
                        busy     <= 1'b1;
                        rom_rd   <= 1'b1;
                        rom_addr <= {level_id, IDX_W'(0)};
                    end
                end
                S_FETCH: begin
                    if (rom_addr[IDX_W-1:0] == IDX_W'(LAST_IDX)) begin
                        rom_rd <= 1'b0;
                        state  <= S_DRAIN;
                    end else begin
                        rom_addr[IDX_W-1:0] <= rom_addr[IDX_W-1:0] + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (commit_c) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read pipeline: remember which word each read was for, data lands next cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cap_vld <= 1'b0;
            cap_idx <= '0;
        end else begin
            cap_vld <= rom_rd;
            cap_idx <= rom_addr[IDX_W-1:0];
        end
    end

    // Shadow bank: route each returned word to its table slot, narrowing fields
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_GROUND; i++) sh_ground[i] <= '0;
            for (int i = 0; i < N_FENCE; i++)  sh_fence[i]  <= '0;
            for (int i = 0; i < N_SPINCE; i++) sh_spince[i] <= '0;
            for (int i = 0; i < 2; i++)        sh_exit[i]   <= '0;
        end else if (cap_vld) begin
            for (int i = 0; i < N_GROUND; i++) begin
                if (cap_idx == IDX_W'(i)) sh_ground[i] <= rom_data;
            end
            for (int i = 0; i < N_FENCE; i++) begin
                if (cap_idx == IDX_W'(FENCE_BASE + i)) sh_fence[i] <= rom_data;
            end
            for (int i = 0; i < N_SPINCE; i++) begin
                if (cap_idx == IDX_W'(SPINCE_BASE + i)) sh_spince[i] <= rom_data[20:0];
            end
            for (int i = 0; i < 2; i++) begin
                if (cap_idx == IDX_W'(EXIT_BASE + i)) sh_exit[i] <= rom_data[9:0];
            end
        end
    end

    // Active bank: whole-level swap in one cycle so a frame never mixes levels
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_GROUND; i++) info_ground[i] <= '0;
            for (int i = 0; i < N_FENCE; i++)  info_fence[i]  <= '0;
            for (int i = 0; i < N_SPINCE; i++) info_spince[i] <= '0;
            for (int i = 0; i < 2; i++)        info_exit[i]   <= '0;
        end else if (commit_c) begin
            info_ground <= sh_ground;
            info_fence  <= sh_fence;
            info_spince <= sh_spince;
            info_exit   <= sh_exit;
        end
    end

endmodule

// File: tb/tb_level_loader.sv
// Bench for level_loader: behavioural level ROM, expected-address and
// expected-level queues drained by a monitor, plus directed timing checks.
module tb_level_loader;

    logic        Clk;
    logic        Reset_n;
    logic        load_req;
    logic [1:0]  level_id;
    logic        frame_end;
    logic        busy;
    logic        done;
    logic        rom_rd;
    logic [7:0]  rom_addr;
    logic [28:0] rom_data;
    logic [28:0] info_ground [16];
    logic [28:0] info_fence  [16];
    logic [20:0] info_spince [6];
    logic [9:0]  info_exit   [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_addr [$];
    int         exp_lvl  [$];

    level_loader #(
        .N_GROUND (16),
        .N_FENCE  (16),
        .N_SPINCE (6),
        .LVL_W    (2)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .load_req    (load_req),
        .level_id    (level_id),
        .frame_end   (frame_end),
        .busy        (busy),
        .done        (done),
        .rom_rd      (rom_rd),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .info_ground (info_ground),
        .info_fence  (info_fence),
        .info_spince (info_spince),
        .info_exit   (info_exit)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM contents: level 1 word k = 0x1000000 + k; other levels add a level tag at bit 6
    function automatic logic [28:0] word(int l, int k);
        return 29'((l << 24) | ((l ^ 1) << 6) | k);
    endfunction

    // Synchronous ROM: data one cycle after the read strobe, junk otherwise
    always @(posedge Clk) begin
        if (rom_rd) rom_data <= word(int'(rom_addr[7:6]), int'(rom_addr[5:0]));
        else        rom_data <= 29'h1555555;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_load(int l, bit will_commit);
        for (int k = 0; k < 40; k++) exp_addr.push_back(8'((l << 6) | k));
        if (will_commit) exp_lvl.push_back(l);
    endtask

    task automatic check_bank(int l);
        for (int i = 0; i < 16; i++)
            chk($sformatf("L%0d ground[%0d]", l, i), 32'(info_ground[i]), 32'(word(l, i)));
        for (int i = 0; i < 16; i++)
            chk($sformatf("L%0d fence[%0d]", l, i), 32'(info_fence[i]), 32'(word(l, 16 + i)));
        for (int i = 0; i < 6; i++)
            chk($sformatf("L%0d spince[%0d]", l, i), 32'(info_spince[i]),
                32'(word(l, 32 + i) & 29'h1FFFFF));
        for (int i = 0; i < 2; i++)
            chk($sformatf("L%0d exit[%0d]", l, i), 32'(info_exit[i]),
                32'(word(l, 38 + i) & 29'h3FF));
    endtask

    task automatic check_zero(string tag);
        logic any;
        any = 1'b0;
        for (int i = 0; i < 16; i++) any |= (info_ground[i] != 0) || (info_fence[i] != 0);
        for (int i = 0; i < 6; i++)  any |= (info_spince[i] != 0);
        for (int i = 0; i < 2; i++)  any |= (info_exit[i] != 0);
        chk({tag, " info_nonzero"}, 32'(any), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
        chk({tag, " rom_rd"}, 32'(rom_rd), 32'h0);
        chk({tag, " rom_addr"}, 32'(rom_addr), 32'h0);
    endtask

    // Monitor: every ROM read and every commit is matched against the queues
    always @(negedge Clk) begin
        if (Reset_n && rom_rd) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected rom_rd addr", 32'(rom_addr), 32'hFFFF);
            end else begin
                chk("rom_addr seq", 32'(rom_addr), 32'(exp_addr.pop_front()));
            end
        end
        if (Reset_n && done) begin
            chk("busy in done cycle", 32'(busy), 32'h0);
            if (exp_lvl.size() == 0) begin
                chk("unexpected done", 32'(done), 32'h0);
            end else begin
                check_bank(exp_lvl.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n   = 1'b0;
        load_req  = 1'b0;
        level_id  = '0;
        frame_end = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(negedge Clk);
        check_zero("reset");

        // Nominal load of level 1, frame boundary at cycle 60
        @(posedge Clk); #1;
        load_req = 1'b1; level_id = 2'd1; push_load(1, 1'b1);
        for (int c = 1; c <= 62; c++) begin
            @(posedge Clk); #1;
            load_req  = 1'b0;
            frame_end = (c == 60);
            @(negedge Clk);
            if (c == 1)  chk("A busy c1", 32'(busy), 32'h1);
            if (c == 40) chk("A rom_rd c40", 32'(rom_rd), 32'h1);
            if (c == 41) chk("A rom_rd drain", 32'(rom_rd), 32'h0);
            if (c == 45) chk("A rom_addr hold", 32'(rom_addr), 32'h67);
            if (c == 30 || c == 60) begin
                chk("A ground3 pre-commit", 32'(info_ground[3]), 32'h0);
                chk("A exit1 pre-commit", 32'(info_exit[1]), 32'h0);
            end
            if (c == 60) begin
                chk("A done c60", 32'(done), 32'h0);
                chk("A busy c60", 32'(busy), 32'h1);
            end
            if (c == 61) begin
                chk("A done c61", 32'(done), 32'h1);
                chk("A busy c61", 32'(busy), 32'h0);
                chk("A ground3", 32'(info_ground[3]), 32'h1000003);
                chk("A fence0", 32'(info_fence[0]), 32'h1000010);
                chk("A spince5", 32'(info_spince[5]), 32'h000025);
                chk("A exit0", 32'(info_exit[0]), 32'h026);
                chk("A exit1", 32'(info_exit[1]), 32'h027);
            end
            if (c == 62) chk("A done c62", 32'(done), 32'h0);
        end

        // Level 0: early frame pulses, rejected request, then back-to-back level 3
        @(posedge Clk); #1;
        load_req = 1'b1; level_id = 2'd0; push_load(0, 1'b1);
        for (int c = 1; c <= 51; c++) begin
            @(posedge Clk); #1;
            load_req  = 1'b0;
            frame_end = (c == 10 || c == 41 || c == 50);
            if (c == 20) begin
                load_req = 1'b1; level_id = 2'd2;
            end
            if (c == 51) begin
                load_req = 1'b1; level_id = 2'd3; push_load(3, 1'b1);
            end
            @(negedge Clk);
            if (c == 11) chk("B done after early fe", 32'(done), 32'h0);
            if (c == 25) chk("B rom_addr after reject", 32'(rom_addr), 32'h18);
            if (c == 42) begin
                chk("B done after drain fe", 32'(done), 32'h0);
                chk("B busy c42", 32'(busy), 32'h1);
            end
            if (c == 50) chk("B old level held", 32'(info_ground[3]), 32'h1000003);
            if (c == 51) chk("B done c51", 32'(done), 32'h1);
        end

        // Back-to-back load, committed at the earliest frame boundary
        for (int c = 1; c <= 44; c++) begin
            @(posedge Clk); #1;
            load_req  = 1'b0;
            frame_end = (c == 42);
            @(negedge Clk);
            if (c == 1) begin
                chk("C rom_addr first", 32'(rom_addr), 32'hC0);
                chk("C busy c1", 32'(busy), 32'h1);
            end
            if (c == 43) begin
                chk("C done min latency", 32'(done), 32'h1);
                chk("C ground0", 32'(info_ground[0]), 32'h3000080);
                chk("C exit0", 32'(info_exit[0]), 32'h0A6);
            end
            if (c == 44) chk("C done c44", 32'(done), 32'h0);
        end

        // Reset mid-fetch of level 2 discards everything
        @(posedge Clk); #1;
        load_req = 1'b1; level_id = 2'd2; push_load(2, 1'b0);
        for (int c = 1; c <= 25; c++) begin
            @(posedge Clk); #1;
            load_req = 1'b0;
            if (c == 25) begin
                Reset_n = 1'b0;
                exp_addr.delete();
            end
        end
        @(negedge Clk);
        check_zero("mid reset");
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(negedge Clk);
        check_zero("post reset");

        // Fresh load after reset restarts at word 0
        @(posedge Clk); #1;
        load_req = 1'b1; level_id = 2'd1; push_load(1, 1'b1);
        for (int c = 1; c <= 43; c++) begin
            @(posedge Clk); #1;
            load_req  = 1'b0;
            frame_end = (c == 42);
            @(negedge Clk);
            if (c == 1)  chk("D rom_addr restart", 32'(rom_addr), 32'h40);
            if (c == 42) chk("D ground3 still zero", 32'(info_ground[3]), 32'h0);
            if (c == 43) chk("D done", 32'(done), 32'h1);
        end

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("leftover expected reads", 32'(exp_addr.size()), 32'h0);
        chk("leftover expected commits", 32'(exp_lvl.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
